// File: rtl/tpll_pkg.sv
// Shared types and constants for the Tiny-PLL loop blocks.
package tpll_pkg;

  // Phase error word passed from the detector to the loop filter.
  typedef logic signed [3:0] err_t;

  localparam err_t ERR_MAX = err_t'(7);
  localparam err_t ERR_MIN = err_t'(-8);

  // Phase detector FSM states; the 2-bit encoding is visible for checkers.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REF_LEAD = 2'd1,
    FB_LEAD  = 2'd2
  } pd_state_t;

endpackage

// File: rtl/edge_sync.sv
// Optional N-flop synchronizer followed by a rising-edge detector.
// STAGES=0 bypasses the synchronizer for inputs already in the clk domain.
module edge_sync
  import tpll_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic synced;
  logic prev;

  generate
    if (STAGES > 0) begin : g_sync
      logic [STAGES-1:0] chain;

      // Shift the raw input through the synchronizer chain.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          chain <= '0;
        end else begin
          chain[0] <= d;
          for (int i = 1; i < STAGES; i++) begin
            chain[i] <= chain[i-1];
          end
        end
      end

      assign synced = chain[STAGES-1];
    end else begin : g_bypass
      assign synced = d;
    end
  endgenerate

  // Remember the previous level; resetting to 0 makes a high level at
  // reset release count as one rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= 1'b0;
    end else begin
      prev <= synced;
    end
  end

  assign rise = synced & ~prev;

endmodule

// File: rtl/phase_detector.sv
// Quantized time-to-digital phase detector: measures the clk-cycle distance
// between reference and feedback rising edges and emits a saturated signed
// error word with a one-cycle sample_en strobe. Positive = reference leads.
//
// Handshake: sample_en is a single-cycle valid with no ready; error_out is
// valid in the cycle sample_en is high and holds its value afterwards.
module phase_detector
  import tpll_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WINDOW      = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic ref_in,
  input  logic fb_in,
  output err_t error_out,
  output logic sample_en,
  output logic cycle_slip
);

  localparam int CW = $clog2(WINDOW + 1);

  logic          ref_rise;
  logic          fb_rise;
  pd_state_t     state;
  logic [CW-1:0] cnt;
  logic [CW:0]   lag;
  logic          timeout;
  err_t          err_pos;
  err_t          err_neg;

  edge_sync #(.STAGES(SYNC_STAGES)) u_ref_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (ref_in),
    .rise (ref_rise)
  );

  edge_sync #(.STAGES(0)) u_fb_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (fb_in),
    .rise (fb_rise)
  );

  // Lag in cycles at the lagging edge is cnt+1; saturate in full width
  // before narrowing so large lags never wrap.
  assign lag     = {1'b0, cnt} + (CW+1)'(1);
  assign timeout = (cnt == CW'(WINDOW - 1));
  assign err_pos = (lag > (CW+1)'(7)) ? ERR_MAX : err_t'(lag[3:0]);
  assign err_neg = (lag > (CW+1)'(7)) ? ERR_MIN : -err_t'(lag[3:0]);

  // Measurement FSM with window counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      error_out  <= '0;
      sample_en  <= 1'b0;
      cycle_slip <= 1'b0;
    end else begin
      sample_en  <= 1'b0;
      cycle_slip <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (ref_rise && fb_rise) begin
              error_out <= '0;
              sample_en <= 1'b1;
            end else if (ref_rise) begin
              state <= REF_LEAD;
            end else if (fb_rise) begin
              state <= FB_LEAD;
            end
          end
          REF_LEAD: begin
            if (fb_rise) begin
              // A simultaneous ref edge opens the next window right away.
              error_out <= err_pos;
              sample_en <= 1'b1;
              cnt       <= '0;
              state     <= ref_rise ? REF_LEAD : IDLE;
            end else if (ref_rise) begin
              error_out  <= ERR_MAX;
              sample_en  <= 1'b1;
              cycle_slip <= 1'b1;
              cnt        <= '0;
            end else if (timeout) begin
              error_out  <= ERR_MAX;
              sample_en  <= 1'b1;
              cycle_slip <= 1'b1;
              cnt        <= '0;
              state      <= IDLE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          FB_LEAD: begin
            if (ref_rise) begin
              error_out <= err_neg;
              sample_en <= 1'b1;
              cnt       <= '0;
              state     <= fb_rise ? FB_LEAD : IDLE;
            end else if (fb_rise) begin
              error_out  <= ERR_MIN;
              sample_en  <= 1'b1;
              cycle_slip <= 1'b1;
              cnt        <= '0;
            end else if (timeout) begin
              error_out  <= ERR_MIN;
              sample_en  <= 1'b1;
              cycle_slip <= 1'b1;
              cnt        <= '0;
              state      <= IDLE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_phase_detector.sv
// Self-checking bench for phase_detector: directed scenarios plus random
// edges, checked every cycle against a timestamp-based reference model.
module tb_phase_detector;
  import tpll_pkg::*;

  localparam int SS  = 2;
  localparam int WIN = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic ref_in = 1'b0;
  logic fb_in = 1'b0;
  err_t error_out;
  logic sample_en;
  logic cycle_slip;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state: who leads and since which cycle
  logic [SS+1:0] ref_hist;
  logic          fb_prev;
  int            lead;      // 0 none, 1 ref, 2 fb
  int            lead_t;
  int            cyc;
  err_t          m_err;
  logic          m_se;
  logic          m_slip;

  // observation counters for directed checks
  int   obs_cnt;
  int   obs_slip;
  err_t obs_last;
  err_t obs_first;
  logic en_v;

  phase_detector #(.SYNC_STAGES(SS), .WINDOW(WIN)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .ref_in     (ref_in),
    .fb_in      (fb_in),
    .error_out  (error_out),
    .sample_en  (sample_en),
    .cycle_slip (cycle_slip)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic emit(input int v, input logic slip);
    m_err  = err_t'(v);
    m_se   = 1'b1;
    m_slip = slip;
  endtask

  // reference model: edges from input history, lag from timestamps
  task automatic model_cycle();
    logic rr, fr;
    int d;
    ref_hist = {ref_hist[SS:0], ref_in};
    rr = ref_hist[SS] & ~ref_hist[SS+1];
    fr = fb_in & ~fb_prev;
    fb_prev = fb_in;
    m_se = 1'b0;
    m_slip = 1'b0;
    d = cyc - lead_t;
    if (!enable) begin
      lead = 0;
    end else if (lead == 0) begin
      if (rr && fr) emit(0, 1'b0);
      else if (rr) begin lead = 1; lead_t = cyc; end
      else if (fr) begin lead = 2; lead_t = cyc; end
    end else if (lead == 1) begin
      if (fr) begin
        emit((d > 7) ? 7 : d, 1'b0);
        if (rr) lead_t = cyc; else lead = 0;
      end else if (rr) begin
        emit(7, 1'b1); lead_t = cyc;
      end else if (d >= WIN) begin
        emit(7, 1'b1); lead = 0;
      end
    end else begin
      if (rr) begin
        emit((d > 8) ? -8 : -d, 1'b0);
        if (fr) lead_t = cyc; else lead = 0;
      end else if (fr) begin
        emit(-8, 1'b1); lead_t = cyc;
      end else if (d >= WIN) begin
        emit(-8, 1'b1); lead = 0;
      end
    end
  endtask

  task automatic check_outputs();
    pd_state_t exp_st;
    exp_st = (lead == 0) ? IDLE : (lead == 1) ? REF_LEAD : FB_LEAD;
    chk("sample_en", {7'd0, sample_en}, {7'd0, m_se});
    chk("cycle_slip", {7'd0, cycle_slip}, {7'd0, m_slip});
    chk("error_out", {4'd0, error_out}, {4'd0, m_err});
    chk("state", {6'd0, dut.state}, {6'd0, exp_st});
    if (sample_en === 1'b1) begin
      if (obs_cnt == 0) obs_first = error_out;
      obs_cnt++;
      obs_last = error_out;
    end
    if (cycle_slip === 1'b1) obs_slip++;
  endtask

  // driver: one clock cycle with the given inputs
  task automatic step(input logic r, input logic f, input logic en);
    @(negedge clk);
    ref_in = r;
    fb_in  = f;
    enable = en;
    @(posedge clk);
    cyc++;
    model_cycle();
    #1;
    check_outputs();
  endtask

  task automatic clear_obs();
    obs_cnt = 0;
    obs_slip = 0;
  endtask

  // three-cycle pulses on ref at r0/r1 and fb at f0 (negative = none)
  task automatic wave(input int len, input int r0, input int r1, input int f0);
    for (int c = 0; c < len; c++) begin
      logic r, f;
      r = (r0 >= 0 && c >= r0 && c < r0 + 3) || (r1 >= 0 && c >= r1 && c < r1 + 3);
      f = (f0 >= 0 && c >= f0 && c < f0 + 3);
      step(r, f, en_v);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ref_in = 1'b0;
    fb_in = 1'b0;
    #1;
    ref_hist = '0;
    fb_prev = 1'b0;
    lead = 0;
    m_err = '0;
    m_se = 1'b0;
    m_slip = 1'b0;
    chk("rst_sample_en", {7'd0, sample_en}, 8'd0);
    chk("rst_cycle_slip", {7'd0, cycle_slip}, 8'd0);
    chk("rst_error_out", {4'd0, error_out}, 8'd0);
    chk("rst_state", {6'd0, dut.state}, {6'd0, IDLE});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic expect_run(input string tag, input int cnt, input int last, input int slips);
    chk({tag, "_strobes"}, 8'(obs_cnt), 8'(cnt));
    chk({tag, "_err"}, {4'd0, obs_last}, {4'd0, 4'(last)});
    chk({tag, "_slips"}, 8'(obs_slip), 8'(slips));
  endtask

  initial begin
    logic rv, fv;
    cyc = 0;
    lead_t = 0;
    en_v = 1'b1;
    obs_last = '0;
    obs_first = '0;
    clear_obs();
    do_reset();

    // aligned edges at the ports (fb two cycles after ref) -> 0
    wave(12, 2, -1, 4);
    expect_run("aligned", 1, 0, 0);
    clear_obs(); wave(16, 2, -1, 9);   expect_run("lag5", 1, 5, 0);
    clear_obs(); wave(12, 5, -1, 4);   expect_run("lead3", 1, -3, 0);
    clear_obs(); wave(24, 2, -1, 16);  expect_run("lag12", 1, 7, 0);
    clear_obs(); wave(32, 20, -1, 2);  expect_run("lead20", 1, -8, 0);

    // reference only: window expires
    clear_obs(); wave(80, 2, -1, -1);  expect_run("timeout", 1, 7, 1);

    // repeated reference edge then feedback
    clear_obs(); wave(26, 2, 12, 18);
    expect_run("repeat", 2, 4, 1);
    chk("repeat_first", {4'd0, obs_first}, {4'd0, ERR_MAX});

    // enable dropped mid-measurement: no strobe, error held
    clear_obs();
    wave(6, 2, -1, -1);
    en_v = 1'b0;
    wave(8, -1, -1, 2);
    chk("en_low_hold", {4'd0, error_out}, 8'd4);
    chk("en_low_idle", {6'd0, dut.state}, {6'd0, IDLE});
    en_v = 1'b1;
    wave(10, 2, -1, -1);
    expect_run("en_low", 0, 4, 0);
    do_reset();
    wave(6, -1, -1, -1);
    expect_run("after_rst", 0, 4, 0);

    // random edges with quiet windows, enable drops and resets
    rv = 1'b0;
    fv = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) rv = ~rv;
      if ($urandom_range(0, 7) == 0) fv = ~fv;
      if (n % 500 >= 400 && n % 500 < 480) begin
        fv = 1'b0;
        rv = (n % 500 >= 402);
      end
      en_v = !(n % 300 >= 290);
      if (n % 1000 == 999) do_reset();
      step(rv, fv, en_v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
